fp_butterfly_scheduler: RTL and testbench

- Shares one non-pipelined floating-point multiplier and one floating-point adder among NUM_REQ butterfly requesters inside the FFT core.
- Arbitrates requests round-robin and issues start pulses to the multiplier and then the adder, each after its fixed latency.
- Returns a done pulse tagged with the requester ID.
- Mul and add slots overlap: a new multiply may start while the previous operation is in the adder.

---
 rtl/fft_fp_pkg.sv | 30 +++
 rtl/fp_rr_arbiter.sv | 86 ++++++++
 rtl/fp_butterfly_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_fp_butterfly_scheduler.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_fp_pkg.sv
// ----------------------------------------------------------------------------
// fft_fp_pkg
// Shared definitions for the FFT core floating-point operator scheduler:
// default operator latencies, requester count/ID width, and the state
// encodings of the multiplier and adder slot FSMs.
// No ports (package).
// ----------------------------------------------------------------------------
package fft_fp_pkg;

    // Default sizing of the shared operator pool
    localparam int FFT_NUM_REQ = 4;
    localparam int FFT_ID_W    = 2;
    localparam int FFT_MUL_LAT = 10;
    localparam int FFT_ADD_LAT = 10;
    localparam int FFT_CNT_W   = 4;

    // Multiplier slot: idle, computing, or finished but waiting for the adder
    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_RUN  = 2'd1,
        M_WAIT = 2'd2
    } mul_state_e;

    // Adder slot: idle or computing
    typedef enum logic {
        A_IDLE = 1'b0,
        A_RUN  = 1'b1
    } add_state_e;

endpackage

// File: rtl/fp_rr_arbiter.sv
// ----------------------------------------------------------------------------
// fp_rr_arbiter
// Picks which butterfly requester gets the shared multiplier next.
// Default build: round-robin, searching from the last winner + 1 with wrap.
// With FP_SCHED_FIXED_PRIO_EN defined: fixed priority (lowest index wins)
// and the pointer register, together with its clock/reset/update ports,
// is removed.
//
// Ports:
//   clk       in   clock (round-robin build only)
//   rst       in   async active-high reset (round-robin build only)
//   update_i  in   a grant is issued this cycle; pointer moves to winner
//   req_i     in   per-requester request levels
//   winner_o  out  index of the selected requester (valid when any_o)
//   any_o     out  at least one request is pending
// ----------------------------------------------------------------------------
module fp_rr_arbiter
    import fft_fp_pkg::*;
#(
    parameter int NUM_REQ = FFT_NUM_REQ,
    parameter int ID_W    = FFT_ID_W
) (
`ifndef FP_SCHED_FIXED_PRIO_EN
    input  logic               clk,
    input  logic               rst,
    input  logic               update_i,
`endif
    input  logic [NUM_REQ-1:0] req_i,
    output logic [ID_W-1:0]    winner_o,
    output logic               any_o
);

    assign any_o = |req_i;

`ifdef FP_SCHED_FIXED_PRIO_EN

    // Lowest set index wins; no history is kept.
    always_comb begin
        logic found;
        found    = 1'b0;
        winner_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_i[i]) begin
                found    = 1'b1;
                winner_o = ID_W'(i);
            end
        end
    end

`else

    logic [ID_W-1:0] ptr_q;

    // Search starts one past the previous winner and wraps, so a requester
    // that holds its request cannot starve the others. The sum is one bit
    // wider than an ID so the wrap works for non-power-of-two NUM_REQ.
    always_comb begin
        logic            found;
        logic [ID_W:0]   idx;
        found    = 1'b0;
        idx      = '0;
        winner_o = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = {1'b0, ptr_q} + (ID_W+1)'(i);
            if (idx >= (ID_W+1)'(NUM_REQ)) begin
                idx = idx - (ID_W+1)'(NUM_REQ);
            end
            if (!found && req_i[idx[ID_W-1:0]]) begin
                found    = 1'b1;
                winner_o = idx[ID_W-1:0];
            end
        end
    end

    // Pointer resets to the last index so requester 0 is favoured first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= ID_W'(NUM_REQ-1);
        end else if (update_i) begin
            ptr_q <= winner_o;
        end
    end

`endif

endmodule

// File: rtl/fp_butterfly_scheduler.sv
// ----------------------------------------------------------------------------
// fp_butterfly_scheduler
// Time-shares one non-pipelined FP multiplier and one FP adder among
// NUM_REQ butterfly requesters. A granted operation occupies the multiplier
// slot for MUL_LAT cycles, is handed to the adder slot for ADD_LAT cycles,
// and then reports done with its requester ID. The two slots overlap: a new
// multiply may start in the same cycle the previous one moves to the adder.
// Build option: FP_SCHED_FIXED_PRIO_EN selects fixed-priority arbitration
// instead of round-robin (see fp_rr_arbiter).
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   async active-high reset
//   ena_fft_core  in   global enable; low blocks new grants only
//   req           in   per-requester request levels
//   gnt           out  one-hot grant pulse
//   mul_start     out  multiplier start pulse
//   mul_sel       out  multiplier operand select (owner of the mul slot)
//   add_start     out  adder start pulse
//   add_sel       out  adder operand select (owner of the add slot)
//   done          out  result-ready pulse
//   done_id       out  requester that owns done
//   busy          out  either slot occupied
// All outputs are registered.
// ----------------------------------------------------------------------------
module fp_butterfly_scheduler
    import fft_fp_pkg::*;
#(
    parameter int NUM_REQ = FFT_NUM_REQ,
    parameter int ID_W    = FFT_ID_W,
    parameter int MUL_LAT = FFT_MUL_LAT,
    parameter int ADD_LAT = FFT_ADD_LAT,
    parameter int CNT_W   = FFT_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena_fft_core,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               mul_start,
    output logic [ID_W-1:0]    mul_sel,
    output logic               add_start,
    output logic [ID_W-1:0]    add_sel,
    output logic               done,
    output logic [ID_W-1:0]    done_id,
    output logic               busy
);

    mul_state_e          mul_state_q, mul_state_d;
    logic [CNT_W-1:0]    mul_cnt_q,   mul_cnt_d;
    logic [ID_W-1:0]     mul_sel_q,   mul_sel_d;
    add_state_e          add_state_q, add_state_d;
    logic [CNT_W-1:0]    add_cnt_q,   add_cnt_d;
    logic [ID_W-1:0]     add_sel_q,   add_sel_d;
    logic [NUM_REQ-1:0]  gnt_q,       gnt_d;
    logic                mul_start_q, mul_start_d;
    logic                add_start_q, add_start_d;
    logic                done_q,      done_d;
    logic [ID_W-1:0]     done_id_q,   done_id_d;
    logic                busy_q,      busy_d;

    logic [ID_W-1:0]     winner;
    logic                any_req;
    logic                add_free;
    logic                mul_finish;
    logic                handoff;
    logic                do_grant;

    fp_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
`ifndef FP_SCHED_FIXED_PRIO_EN
        .clk      (clk),
        .rst      (rst),
        .update_i (do_grant),
`endif
        .req_i    (req),
        .winner_o (winner),
        .any_o    (any_req)
    );

    // The adder can accept a new operation when idle or on its last cycle.
    // A multiply is ready to move on at the end of its count or while stalled.
    // A grant may coincide with the handoff that frees the multiplier.
    always_comb begin
        add_free   = (add_state_q == A_IDLE) || (add_cnt_q == '0);
        mul_finish = ((mul_state_q == M_RUN) && (mul_cnt_q == '0)) ||
                     (mul_state_q == M_WAIT);
        handoff    = mul_finish && add_free;
        do_grant   = ((mul_state_q == M_IDLE) || handoff) &&
                     ena_fft_core && any_req;
    end

    // Next-state logic for both slots and the registered output pulses.
    always_comb begin
        mul_state_d = mul_state_q;
        mul_cnt_d   = mul_cnt_q;
        mul_sel_d   = mul_sel_q;
        add_state_d = add_state_q;
        add_cnt_d   = add_cnt_q;
        add_sel_d   = add_sel_q;
        gnt_d       = '0;
        mul_start_d = 1'b0;
        add_start_d = 1'b0;
        done_d      = 1'b0;
        done_id_d   = done_id_q;

        case (mul_state_q)
            M_IDLE: ;
            M_RUN: begin
                if (mul_cnt_q != '0) begin
                    mul_cnt_d = mul_cnt_q - CNT_W'(1);
                end else if (!add_free) begin
                    mul_state_d = M_WAIT;
                end
            end
            M_WAIT: ;
            default: mul_state_d = M_IDLE;
        endcase

        if (handoff) begin
            mul_state_d = M_IDLE;
        end

        if (do_grant) begin
            mul_state_d   = M_RUN;
            mul_cnt_d     = CNT_W'(MUL_LAT-1);
            mul_sel_d     = winner;
            gnt_d[winner] = 1'b1;
            mul_start_d   = 1'b1;
        end

        if (add_state_q == A_RUN) begin
            if (add_cnt_q != '0) begin
                add_cnt_d = add_cnt_q - CNT_W'(1);
            end else begin
                done_d      = 1'b1;
                done_id_d   = add_sel_q;
                add_state_d = A_IDLE;
            end
        end

        // A handoff on the adder's last cycle reloads it for the new owner.
        if (handoff) begin
            add_state_d = A_RUN;
            add_cnt_d   = CNT_W'(ADD_LAT-1);
            add_sel_d   = mul_sel_q;
            add_start_d = 1'b1;
        end

        busy_d = (mul_state_d != M_IDLE) || (add_state_d == A_RUN);
    end

    // State and output registers; reset aborts any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_state_q <= M_IDLE;
            mul_cnt_q   <= '0;
            mul_sel_q   <= '0;
            add_state_q <= A_IDLE;
            add_cnt_q   <= '0;
            add_sel_q   <= '0;
            gnt_q       <= '0;
            mul_start_q <= 1'b0;
            add_start_q <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            mul_state_q <= mul_state_d;
            mul_cnt_q   <= mul_cnt_d;
            mul_sel_q   <= mul_sel_d;
            add_state_q <= add_state_d;
            add_cnt_q   <= add_cnt_d;
            add_sel_q   <= add_sel_d;
            gnt_q       <= gnt_d;
            mul_start_q <= mul_start_d;
            add_start_q <= add_start_d;
            done_q      <= done_d;
            done_id_q   <= done_id_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt       = gnt_q;
    assign mul_start = mul_start_q;
    assign mul_sel   = mul_sel_q;
    assign add_start = add_start_q;
    assign add_sel   = add_sel_q;
    assign done      = done_q;
    assign done_id   = done_id_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fp_butterfly_scheduler.sv
// ----------------------------------------------------------------------------
// tb_fp_butterfly_scheduler
// Directed bench for fp_butterfly_scheduler. dutA uses the default latencies
// (MUL_LAT=10, ADD_LAT=10); dutB uses ADD_LAT=15 so a second multiply has to
// stall waiting for the adder. A monitor logs the cycle of every grant,
// add_start and done so latencies can be compared against hand-computed
// offsets from the first grant.
// ----------------------------------------------------------------------------
module tb_fp_butterfly_scheduler;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [3:0] reqA, reqB;
    logic [3:0] gntA, gntB;
    logic       mulStartA, addStartA, doneA, busyA;
    logic       mulStartB, addStartB, doneB, busyB;
    logic [1:0] mulSelA, addSelA, doneIdA;
    logic [1:0] mulSelB, addSelB, doneIdB;

    int total;
    int bad;
    int cyc;

    int gntCycA[$], gntIdxA[$], mulCycA[$], addCycA[$], addSelQA[$], doneCycA[$], doneIdQA[$];
    int gntCycB[$], gntIdxB[$], addCycB[$], addSelQB[$], doneCycB[$], doneIdQB[$];

    fp_butterfly_scheduler dutA (
        .clk          (clk),
        .rst          (rst),
        .ena_fft_core (ena),
        .req          (reqA),
        .gnt          (gntA),
        .mul_start    (mulStartA),
        .mul_sel      (mulSelA),
        .add_start    (addStartA),
        .add_sel      (addSelA),
        .done         (doneA),
        .done_id      (doneIdA),
        .busy         (busyA)
    );

    fp_butterfly_scheduler #(.ADD_LAT(15)) dutB (
        .clk          (clk),
        .rst          (rst),
        .ena_fft_core (ena),
        .req          (reqB),
        .gnt          (gntB),
        .mul_start    (mulStartB),
        .mul_sel      (mulSelB),
        .add_start    (addStartB),
        .add_sel      (addSelB),
        .done         (doneB),
        .done_id      (doneIdB),
        .busy         (busyB)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something hangs outside a bounded wait
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int oneHotIdx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Event log sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (gntA != 4'b0) begin
            gntCycA.push_back(cyc);
            gntIdxA.push_back(oneHotIdx(gntA));
        end
        if (mulStartA) mulCycA.push_back(cyc);
        if (addStartA) begin
            addCycA.push_back(cyc);
            addSelQA.push_back(int'(addSelA));
        end
        if (doneA) begin
            doneCycA.push_back(cyc);
            doneIdQA.push_back(int'(doneIdA));
        end
        if (gntB != 4'b0) begin
            gntCycB.push_back(cyc);
            gntIdxB.push_back(oneHotIdx(gntB));
        end
        if (addStartB) begin
            addCycB.push_back(cyc);
            addSelQB.push_back(int'(addSelB));
        end
        if (doneB) begin
            doneCycB.push_back(cyc);
            doneIdQB.push_back(int'(doneIdB));
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        if (obs !== exp) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic en);
        reqA = a;
        reqB = b;
        ena  = en;
    endtask

    // Each step lands 1 ns after a falling edge, after the monitor has run
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clearQueues();
        gntCycA.delete(); gntIdxA.delete(); mulCycA.delete(); addCycA.delete();
        addSelQA.delete(); doneCycA.delete(); doneIdQA.delete();
        gntCycB.delete(); gntIdxB.delete(); addCycB.delete();
        addSelQB.delete(); doneCycB.delete(); doneIdQB.delete();
    endtask

    task automatic applyReset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic waitGnt(input string tag, input bit useB, input int maxCycles);
        for (int i = 0; i < maxCycles; i++) begin
            step(1);
            if ((useB ? gntB : gntA) != 4'b0) return;
        end
        checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    int t0;
    int expIdx;

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        rst   = 1'b1;
        applyStimulus(4'b0, 4'b0, 1'b0);
        step(3);
        rst = 1'b0;
        step(1);

        // Reset state
        checkOutput("rst_gnt",       32'(gntA),      32'd0);
        checkOutput("rst_mul_start", 32'(mulStartA), 32'd0);
        checkOutput("rst_add_start", 32'(addStartA), 32'd0);
        checkOutput("rst_done",      32'(doneA),     32'd0);
        checkOutput("rst_busy",      32'(busyA),     32'd0);
        checkOutput("rst_sels",      32'({mulSelA, addSelA, doneIdA}), 32'd0);
        checkOutput("rst_busyB",     32'(busyB),     32'd0);

        // Single operation from requester 0
        clearQueues();
        applyStimulus(4'b0001, 4'b0, 1'b1);
        waitGnt("t1_gnt", 1'b0, 5);
        checkOutput("t1_gnt_vec",   32'(gntA),      32'd1);
        checkOutput("t1_mul_start", 32'(mulStartA), 32'd1);
        checkOutput("t1_mul_sel",   32'(mulSelA),   32'd0);
        checkOutput("t1_busy",      32'(busyA),     32'd1);
        applyStimulus(4'b0, 4'b0, 1'b1);
        step(22);
        checkOutput("t1_ngnt",      32'(gntCycA.size()),  32'd1);
        checkOutput("t1_nadd",      32'(addCycA.size()),  32'd1);
        checkOutput("t1_add_lat",   32'(addCycA[0] - gntCycA[0]),  32'd10);
        checkOutput("t1_add_sel",   32'(addSelQA[0]),     32'd0);
        checkOutput("t1_ndone",     32'(doneCycA.size()), 32'd1);
        checkOutput("t1_done_lat",  32'(doneCycA[0] - gntCycA[0]), 32'd20);
        checkOutput("t1_done_id",   32'(doneIdQA[0]),     32'd0);

        // All four requesting: one grant per multiplier slot
        applyReset();
        clearQueues();
        applyStimulus(4'b1111, 4'b0, 1'b1);
        for (int i = 0; i < 60; i++) begin
            step(1);
            if (gntCycA.size() >= 4) break;
        end
        applyStimulus(4'b0, 4'b0, 1'b1);
        for (int i = 0; i < 60; i++) begin
            if (doneCycA.size() >= 4) break;
            step(1);
        end
        checkOutput("t2_ngnt",  32'(gntCycA.size()),  32'd4);
        checkOutput("t2_nmul",  32'(mulCycA.size()),  32'd4);
        checkOutput("t2_ndone", 32'(doneCycA.size()), 32'd4);
        t0 = gntCycA[0];
        for (int i = 0; i < 4; i++) begin
`ifdef FP_SCHED_FIXED_PRIO_EN
            expIdx = 0;
`else
            expIdx = i;
`endif
            checkOutput($sformatf("t2_gnt_idx%0d", i),  32'(gntIdxA[i]),       32'(expIdx));
            checkOutput($sformatf("t2_mul_cyc%0d", i),  32'(mulCycA[i] - t0),  32'(10 * i));
            checkOutput($sformatf("t2_done_cyc%0d", i), 32'(doneCycA[i] - t0), 32'(20 + 10 * i));
            checkOutput($sformatf("t2_done_id%0d", i),  32'(doneIdQA[i]),      32'(expIdx));
        end

        // Adder slower than multiplier: second handoff stalls
        applyReset();
        clearQueues();
        applyStimulus(4'b0, 4'b0110, 1'b1);
        waitGnt("t3_gnt0", 1'b1, 5);
        applyStimulus(4'b0, 4'b0100, 1'b1);
        waitGnt("t3_gnt1", 1'b1, 15);
        applyStimulus(4'b0, 4'b0, 1'b1);
        for (int i = 0; i < 50; i++) begin
            if (doneCycB.size() >= 2) break;
            step(1);
        end
        t0 = gntCycB[0];
        checkOutput("t3_ngnt",      32'(gntCycB.size()),    32'd2);
        checkOutput("t3_gnt_idx0",  32'(gntIdxB[0]),        32'd1);
        checkOutput("t3_gnt_idx1",  32'(gntIdxB[1]),        32'd2);
        checkOutput("t3_gnt1_cyc",  32'(gntCycB[1] - t0),   32'd10);
        checkOutput("t3_nadd",      32'(addCycB.size()),    32'd2);
        checkOutput("t3_add0_cyc",  32'(addCycB[0] - t0),   32'd10);
        checkOutput("t3_add1_cyc",  32'(addCycB[1] - t0),   32'd25);
        checkOutput("t3_add1_sel",  32'(addSelQB[1]),       32'd2);
        checkOutput("t3_ndone",     32'(doneCycB.size()),   32'd2);
        checkOutput("t3_done0_cyc", 32'(doneCycB[0] - t0),  32'd25);
        checkOutput("t3_done1_cyc", 32'(doneCycB[1] - t0),  32'd40);
        checkOutput("t3_done_ids",  32'({doneIdQB[0][1:0], doneIdQB[1][1:0]}), 32'b0110);

        // Enable dropped mid-operation: no new grants, in-flight op completes
        applyReset();
        clearQueues();
        applyStimulus(4'b0001, 4'b0, 1'b1);
        waitGnt("t4_gnt", 1'b0, 5);
        applyStimulus(4'b0, 4'b0, 1'b1);
        step(3);
        applyStimulus(4'b1111, 4'b0, 1'b0);
        step(16);
        checkOutput("t4_busy_t19", 32'(busyA),   32'd1);
        step(1);
        checkOutput("t4_done_t20", 32'(doneA),   32'd1);
        checkOutput("t4_done_id",  32'(doneIdA), 32'd0);
        step(1);
        checkOutput("t4_busy_t21", 32'(busyA),   32'd0);
        checkOutput("t4_ngnt",     32'(gntCycA.size()), 32'd1);
        applyStimulus(4'b0, 4'b0, 1'b1);

        // Reset during the add slot aborts everything
        applyReset();
        clearQueues();
        applyStimulus(4'b0010, 4'b0, 1'b1);
        waitGnt("t5_gnt", 1'b0, 5);
        applyStimulus(4'b0, 4'b0, 1'b1);
        step(12);
        checkOutput("t5_busy_pre",    32'(busyA),   32'd1);
        checkOutput("t5_add_sel_pre", 32'(addSelA), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("t5_busy_rst",    32'(busyA),   32'd0);
        checkOutput("t5_sels_rst",    32'({mulSelA, addSelA, doneIdA}), 32'd0);
        checkOutput("t5_pulses_rst",  32'({gntA, mulStartA, addStartA, doneA}), 32'd0);
        step(2);
        rst = 1'b0;
        step(15);
        checkOutput("t5_ndone", 32'(doneCycA.size()), 32'd0);
        applyStimulus(4'b1111, 4'b0, 1'b1);
        waitGnt("t5_regnt", 1'b0, 5);
        checkOutput("t5_first_gnt", 32'(gntA), 32'b0001);
        applyStimulus(4'b0, 4'b0, 1'b1);
        step(25);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
